// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle MSB-first magnitude comparator with cascade input and valid/ready handshakes.
module comparator_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    input  logic             in_l,
    input  logic             in_g,
    input  logic             in_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             l,
    output logic             g,
    output logic             m
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t state, nxt;
    logic [IW-1:0] idx;
    logic [WIDTH-1:0] a_q, b_q, sbit;
    logic [DIGIT-1:0] da, db;
    logic c_l, c_g, rdy, load, nl, ng, nm;
    logic cas_unused;
    // in_m adds nothing under the l > g > m priority: l=0 and g=0 already means m
    assign cas_unused = in_m;
    // flipping the operand MSB at capture turns a signed compare into an unsigned one
    assign sbit = WIDTH'(sgn) << (WIDTH - 1);
    assign da = a_q[WIDTH-1 -: DIGIT];
    assign db = b_q[WIDTH-1 -: DIGIT];
    assign in_ready = rdy && state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        nxt = state;
        load = 1'b0;
        nl = 1'b0;
        ng = 1'b0;
        nm = 1'b0;
        case (state)
            IDLE: nxt = (in_valid && rdy) ? CMP : IDLE;
            CMP: begin
                nl = c_l || (c_g && da > db);
                nm = !c_l && (!c_g || da < db);
                ng = !c_l && c_g && da == db && idx == '0;
                load = nl || nm || ng;
                nxt = load ? DONE : CMP;
            end
            DONE: nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            rdy <= 1'b0;
            l <= 1'b0;
            g <= 1'b0;
            m <= 1'b0;
        end else begin
            state <= nxt;
            rdy <= 1'b1;
            if (in_ready && in_valid) begin
                a_q <= a ^ sbit;
                b_q <= b ^ sbit;
                c_l <= in_l;
                c_g <= in_g;
                idx <= IW'(NDIG - 1);
            end else if (state == CMP && !load) begin
                a_q <= a_q << DIGIT;
                b_q <= b_q << DIGIT;
                idx <= idx - 1'b1;
            end
            if (load) {l, g, m} <= {nl, ng, nm};
        end
    end
endmodule
